// File: rtl/elastic_pipe_reg_pkg.sv
// Shared types and helpers for the elastic pipeline register and its stages.
// Holds no sizing constants; each user derives its own widths.
package elastic_pipe_reg_pkg;

    typedef struct packed {
        logic load;
        logic clear;
    } stage_ctl_t;

    // A stage moves when it is empty or the stage downstream moves too.
    function automatic logic stage_advance(input logic vld, input logic next_adv);
        return ~vld | next_adv;
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One pipeline slot: a valid bit plus payload. Clear wins over load.
// Payload is written only by a valid word, so an emptied slot keeps its last data.
module elastic_pipe_stage
    import elastic_pipe_reg_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] CLR_VALUE   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  stage_ctl_t       ctl_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (ctl_i.clear) begin
            vld_d  = 1'b0;
            data_d = CLR_VALUE;
        end else if (ctl_i.load) begin
            vld_d = vld_i;
            if (vld_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            data_q <= RESET_VALUE;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Bubble-collapsing valid/ready pipeline, DEPTH cycles latency, one word/cycle; stalls hold all state.
// PIPE_SKID_EN adds a skid entry ahead of stage 0 so ready_o is a flop (capacity DEPTH+1).
module elastic_pipe_reg
    import elastic_pipe_reg_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] CLR_VALUE   = '0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [WIDTH-1:0]            data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [WIDTH-1:0]            data_o,
    input  logic                        flush,
    output logic [$clog2(DEPTH+2)-1:0]  count_o
);

    localparam int CW = $clog2(DEPTH+2);

    logic [DEPTH-1:0]            stg_vld;
    logic [DEPTH-1:0]            stg_adv;
    logic [DEPTH-1:0][WIDTH-1:0] stg_dat;
    logic                        in_vld;
    logic [WIDTH-1:0]            in_dat;
    logic                        in_xfer;
    logic                        out_xfer;
    logic [CW-1:0]               count_q, count_d;

`ifdef PIPE_SKID_EN
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;

    assign ready_o = ~skid_vld_q;
    assign in_xfer = valid_i & ready_o;
    // A parked word has priority; it can only exist while ready_o is low.
    assign in_vld  = skid_vld_q | in_xfer;
    assign in_dat  = skid_vld_q ? skid_dat_q : data_i;

    always_comb begin
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            skid_vld_d = 1'b0;
            skid_dat_d = CLR_VALUE;
        end else if (skid_vld_q && stg_adv[0]) begin
            skid_vld_d = 1'b0;
        end else if (in_xfer && !stg_adv[0]) begin
            skid_vld_d = 1'b1;
            skid_dat_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            skid_vld_q <= 1'b0;
            skid_dat_q <= RESET_VALUE;
        end else begin
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end
`else
    assign ready_o = stg_adv[0];
    assign in_xfer = valid_i & ready_o;
    assign in_vld  = in_xfer;
    assign in_dat  = data_i;
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        stage_ctl_t       ctl;
        logic             src_vld;
        logic [WIDTH-1:0] src_dat;

        if (k == DEPTH-1) begin : g_last
            assign stg_adv[k] = stage_advance(stg_vld[k], ready_i);
        end else begin : g_mid
            assign stg_adv[k] = stage_advance(stg_vld[k], stg_adv[k+1]);
        end

        if (k == 0) begin : g_first
            assign src_vld = in_vld;
            assign src_dat = in_dat;
        end else begin : g_chain
            assign src_vld = stg_vld[k-1];
            assign src_dat = stg_dat[k-1];
        end

        assign ctl.load  = stg_adv[k];
        assign ctl.clear = flush;

        elastic_pipe_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE),
            .CLR_VALUE   (CLR_VALUE)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .ctl_i   (ctl),
            .vld_i   (src_vld),
            .data_i  (src_dat),
            .vld_o   (stg_vld[k]),
            .data_o  (stg_dat[k])
        );
    end

    assign valid_o  = stg_vld[DEPTH-1];
    assign data_o   = stg_dat[DEPTH-1];
    assign out_xfer = valid_o & ready_i;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed plus random bench for elastic_pipe_reg (WIDTH=32, DEPTH=2) in either PIPE_SKID_EN setting.
// Reference model: ordered queue of words with their pipeline position.
module tb_elastic_pipe_reg;

    localparam int          W  = 32;
    localparam int          D  = 2;
    localparam logic [31:0] RV = 32'h0000DEAD;
    localparam logic [31:0] CV = 32'h0000C1EA;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int CAP = D + (SKID ? 1 : 0);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [W-1:0]  data_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [W-1:0]  data_o;
    logic          flush = 1'b0;
    logic [1:0]    count_o;

    elastic_pipe_reg #(
        .WIDTH       (W),
        .DEPTH       (D),
        .RESET_VALUE (RV),
        .CLR_VALUE   (CV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .flush   (flush),
        .count_o (count_o)
    );

    always #5 clk = ~clk;

    // pos: 0..D-1 pipeline slot, -1 parked in the skid entry
    typedef struct {
        logic [31:0] d;
        int          pos;
    } ent_t;

    ent_t        q[$];
    bit          idle_known;
    logic [31:0] idle_data;
    int          checks = 0;
    int          failures = 0;

    function automatic logic model_ready(input logic r);
        if (SKID) return (q.size() != D + 1);
        return (q.size() < D) || r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        ev = (q.size() > 0) && (q[0].pos == D - 1);
        check("valid_o", 32'(valid_o), 32'(ev));
        if (ev) check("data_o", data_o, q[0].d);
        else if (idle_known) check("data_o_idle", data_o, idle_data);
        check("count_o", 32'(count_o), 32'(q.size()));
        check("ready_o", 32'(ready_o), 32'(model_ready(ready_i)));
        ready_i = ~ready_i;
        #1;
        check("ready_o_probe", 32'(ready_o), 32'(model_ready(ready_i)));
        ready_i = ~ready_i;
        #1;
    endtask

    task automatic model_edge(input logic acc, input logic fl, input logic [31:0] d, input logic r);
        int   lim;
        int   np;
        ent_t e;
        if (fl) begin
            q.delete();
            idle_known = 1'b1;
            idle_data  = CV;
            return;
        end
        if (q.size() > 0 && q[0].pos == D - 1 && r) begin
            void'(q.pop_front());
            idle_known = 1'b0;
        end
        lim = D - 1;
        for (int i = 0; i < q.size(); i++) begin
            e  = q[i];
            np = (e.pos + 1 < lim) ? e.pos + 1 : lim;
            e.pos = np;
            q[i]  = e;
            lim   = np - 1;
        end
        if (acc) begin
            e.d   = d;
            e.pos = (lim >= 0) ? 0 : -1;
            q.push_back(e);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic fl);
        logic acc;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush   = fl;
        @(negedge clk);
        check_outputs();
        acc = v && model_ready(r);
        @(posedge clk);
        model_edge(acc, fl, d, r);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        flush   = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'h55;
        ready_i = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        flush   = 1'b0;
        valid_i = 1'b0;
        q.delete();
        idle_known = 1'b1;
        idle_data  = RV;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        logic will;

        // reset state
        do_reset();
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_data_o", data_o, RV);
        check("rst_count_o", 32'(count_o), 32'd0);
        check("rst_ready_o", 32'(ready_o), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // stream 1..8 at full rate
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 32'(i), 1'b1, 1'b0);
            if (i == 2) check("stream_latency", data_o, 32'h1);
            if (i >= 2) check("stream_count", 32'(count_o), 32'd2);
        end
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);

        // full stall then drain
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b1, 32'hD, 1'b0, 1'b0);
        step(1'b1, 32'hE, 1'b0, 1'b0);
        check("stall_ready_o", 32'(ready_o), 32'd0);
        check("stall_count_o", 32'(count_o), 32'(CAP));
        check("stall_data_o", data_o, 32'hA);
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0);

        // bubble collapse
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("bubble_count_o", 32'(count_o), 32'd2);
        check("bubble_data_o", data_o, 32'h11);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("bubble_no_gap", data_o, 32'h22);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);

        // flush with a simultaneous word
        step(1'b1, 32'h44, 1'b0, 1'b0);
        step(1'b1, 32'h55, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b1, 1'b1);
        check("flush_valid_o", 32'(valid_o), 32'd0);
        check("flush_count_o", 32'(count_o), 32'd0);
        check("flush_data_o", data_o, CV);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);

        // reset with flush mid-stream
        step(1'b1, 32'h66, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b0);
        do_reset();
        check("rstprio_data_o", data_o, RV);
        check("rstprio_valid_o", 32'(valid_o), 32'd0);
        check("rstprio_ready_o", 32'(ready_o), 32'd1);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);

        // ready_i toggling every cycle, 100 words
        sent = 0;
        for (int c = 0; c < 600 && sent < 100; c++) begin
            will = model_ready(1'(c % 2));
            step(1'b1, 32'h1000 + 32'(sent), 1'(c % 2), 1'b0);
            if (will) sent++;
        end
        check("toggle_sent", 32'(sent), 32'd100);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("toggle_drained", 32'(count_o), 32'd0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), $urandom(),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0));
        end
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("final_count", 32'(count_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elastic_pipe_reg.md
ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 The block SHALL have parameter RESET_VALUE, default 0, data value loaded into every stage on reset.
REQ-004 The block SHALL have parameter CLR_VALUE, default 0, data value loaded into every stage on flush.
REQ-005 The block SHALL have port clk, input, 1, the single clock; one clock domain, all state on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-007 The block SHALL have port valid_i, input, 1, upstream data valid.
REQ-008 The block SHALL have port ready_o, output, 1, block can accept this cycle.
REQ-009 The block SHALL have port data_i, input, WIDTH, upstream payload.
REQ-010 The block SHALL have port valid_o, output, 1, output stage holds valid data.
REQ-011 The block SHALL have port ready_i, input, 1, downstream accepts this cycle.
REQ-012 The block SHALL have port data_o, output, WIDTH, payload of the last stage.
REQ-013 The block SHALL have port flush, input, 1, discard all held entries.
REQ-014 The block SHALL have port count_o, output, $clog2(DEPTH+2), number of valid entries held, including the skid entry.

Function
REQ-015 A transfer SHALL occur on a clock edge where valid and ready are both 1 (input side: valid_i&ready_o; output side: valid_o&ready_i).
REQ-016 Stage k SHALL advance when it is empty or stage k+1 advances; the last stage advances when it is empty or ready_i=1 (bubble-collapsing).
REQ-017 ready_o SHALL be combinational, equal to stage-0 advance, when PIPE_SKID_EN is undefined.
REQ-018 An accepted word SHALL appear on valid_o/data_o exactly DEPTH cycles after acceptance with no stall; sustained throughput SHALL be one word per cycle.
REQ-019 Words SHALL leave in acceptance order; none duplicated, none dropped except by flush.
REQ-020 data_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-021 A stage that is not loaded SHALL retain its data; an emptied stage's data is don't-care but SHALL NOT change data_o while valid_o=0 unless loaded.
REQ-022 flush=1 SHALL clear every valid bit, including skid, load CLR_VALUE into every stage, and force count_o to 0 next cycle.
REQ-023 flush SHALL override a simultaneous input acceptance: the word is discarded. ready_o during flush follows REQ-017/REQ-029 unchanged.
REQ-024 count_o SHALL increment on input transfer, decrement on output transfer, hold on both or neither, and never exceed capacity (DEPTH, or DEPTH+1 with skid).
REQ-025 With all stages full and ready_i=0, ready_o SHALL be 0 and no state SHALL change.

Reset
REQ-026 While reset_n=0 at a clock edge, all valid bits SHALL clear and all stages SHALL load RESET_VALUE.
REQ-027 After reset: valid_o=0, data_o=RESET_VALUE, count_o=0, and ready_o=1.
REQ-028 reset_n=0 SHALL have priority over flush and any handshake; reset mid-stream discards all held words.

Configuration
REQ-029 Macro PIPE_SKID_EN: when defined, a one-entry skid buffer SHALL sit before stage 0, and ready_o SHALL come from a flop equal to ~skid_valid, with no combinational path from ready_i.
REQ-030 With PIPE_SKID_EN defined:
- A word accepted while stage 0 cannot advance SHALL be captured in the skid entry.
- Stage 0 SHALL load from the skid entry in preference to data_i.
- Latency with no stall SHALL remain DEPTH.
- Capacity SHALL be DEPTH+1.
REQ-031 Without PIPE_SKID_EN, no skid storage SHALL be built, and behaviour SHALL be exactly REQ-015..REQ-025.

Structure
REQ-032 Pipeline payload structs (if_id_reg_t etc.) SHALL stay in the shared riscv_types package; instantiations SHALL pass WIDTH=$bits(type).
REQ-033 No new package constants SHALL be added; the count width SHALL be computed locally.
REQ-034 One sub-module, elastic_pipe_stage (one valid bit plus WIDTH data, load/clear inputs), SHALL be generated DEPTH times.

Verification
REQ-035 The bench SHALL cover these directed scenarios (WIDTH=32, DEPTH=2, both macro settings):
- Stream: reset, then stream 0x1..0x8 with ready_i=1 -> data_o shows 0x1 two cycles after first accept, then one word per cycle; count_o steady at 2.
- Full stall: ready_i=0, push 0xA,0xB (0xA,0xB,0xC with skid) -> ready_o=0 afterwards; count_o=2 (3); data_o=0xA held; release ready_i -> drains in order.
- Bubble collapse: push 0x11, idle one cycle, push 0x22, with ready_i=0 -> both held in adjacent stages; count_o=2; no gap on drain.
- Flush: flush with 2 entries plus a simultaneous valid_i word 0x33 -> next cycle valid_o=0, count_o=0, data_o=CLR_VALUE; 0x33 never emerges.
- Reset priority: reset_n=0 together with flush=1 mid-stream -> data_o=RESET_VALUE (set 0xDEAD), valid_o=0, ready_o=1 after release.
- Skid timing (PIPE_SKID_EN only): ready_i toggled every cycle -> ready_o is never a same-cycle function of ready_i; no loss or reorder over 100 words.
